// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

  // At least one bit so the index register never collapses to zero width.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice; the one shared adder used by the serial controller.
module cla_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice reused over WIDTH/4 cycles,
// inter-nibble carry held in a register, result registered with a done strobe.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic [WIDTH-1:0]    s_next;

  cla_4bit u_slice (
    .A    (a_sh_q[NIBBLE_W-1:0]),
    .B    (b_sh_q[NIBBLE_W-1:0]),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  // Each new nibble enters at the top, so after NIB steps the LSB nibble sits at [3:0].
  assign s_next = {nib_sum, s_sh_q[WIDTH-1:NIBBLE_W]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          s_sh_d  = '0;
          carry_d = cin;
          idx_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      RUN: begin
        a_sh_d  = {{NIBBLE_W{1'b0}}, a_sh_q[WIDTH-1:NIBBLE_W]};
        b_sh_d  = {{NIBBLE_W{1'b0}}, b_sh_q[WIDTH-1:NIBBLE_W]};
        s_sh_d  = s_next;
        carry_d = nib_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = s_next;
          cout_d  = nib_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (s_next[WIDTH-1] != a_msb_q);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Nibble-serial wide-adder controller. It adds two WIDTH-bit operands by time-multiplexing one `cla_4bit` slice over WIDTH/4 cycles, holding the inter-nibble carry in a register. It sits between a requester issuing `start` pulses and the shared 4-bit adder datapath, and returns a registered result with a one-cycle `done` strobe. It is the area-minimal alternative to instantiating a full-width CLA or ripple adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle strobe; high while in DONE.
- sum  out  WIDTH  registered result; held until the next completion.
- cout  out  1  carry out of bit WIDTH-1; held with `sum`.
- ovf  out  1  two's-complement overflow; held with `sum`.

## Operation
- FSM states:
  - IDLE: if `start`, load working registers, set carry to `cin` and index to 0, then go to RUN.
  - RUN: one nibble per cycle. At index NIB-1, go to DONE.
  - DONE: if `start`, reload as from IDLE and go to RUN; otherwise go to IDLE.
- Working registers:
  - `a_sh` and `b_sh` (WIDTH) shift right by 4 each RUN cycle.
  - `s_sh` (WIDTH) shifts right by 4, with the new sum nibble inserted at [WIDTH-1:WIDTH-4].
  - `carry` is 1 bit; `idx` is $clog2(NIB) bits.
- Adder slice inputs are `a_sh[3:0]`, `b_sh[3:0]` and `carry`. Its `Cout` updates `carry` every RUN cycle.
- On the RUN→DONE edge, the result registers load:
  - `sum` ← final `s_sh` including the last nibble.
  - `cout` ← final slice `Cout`.
  - `ovf` ← (a_orig[W-1]==b_orig[W-1]) && (sum[W-1]!=a_orig[W-1]).
  - The MSBs of the original operands are latched at accept for this purpose.
- `sum`, `cout` and `ovf` change only on that edge. They are stable at all other times, including during a following RUN.
- `start` while in RUN is ignored: no queueing, no abort, no error flag.
- Reset (any state, including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Working registers are cleared.
  - No `done` is produced for the aborted operation.
- `idx` counts 0 to NIB-1 and never wraps within an operation.

## Timing
- Accept edge E0 (state IDLE or DONE with start=1).
- Nibble k is computed on edge E(k+1), for k=0..NIB-1. `busy`=1 from after E0 until after E(NIB).
- `done`=1 for exactly one cycle, between E(NIB) and E(NIB+1). `sum`, `cout` and `ovf` are valid from E(NIB) onward.
- Latency: NIB cycles from accept to `done`. For WIDTH=16 this is 4.
- Minimum issue interval is NIB+1 cycles, achieved with `start` asserted during the `done` cycle.
- Combinational path per cycle: one 4-bit slice plus register setup. There is no path from input ports to outputs.

## Structure
- Package `serial_add_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - localparam NIBBLE_W=4.
  - function for NIB and counter width.
- One sub-module: a single `cla_4bit` instance (ports A, B, Cin, Sum, Cout) as the shared slice.
- `ripple_carry_adder_4bit` must be drop-in swappable, with identical results required.

## Test plan
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0; done exactly 4 cycles after accept, one cycle wide.
- a=16'h7FFF, b=16'h0001, cin=0 → sum=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h8000 → sum=16'h0000, cout=1, ovf=1.
- a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0, ovf=0. Check that busy is high for exactly 4 cycles.
- Pulse start with new operands mid-RUN → ignored; the original result and done timing are unchanged. The previous sum is held stable during RUN.
- Assert rst at the 2nd RUN cycle → all outputs are 0 next cycle, no done appears, and the next start completes correctly.
- Assert start during the done cycle with a=16'h00FF, b=16'h0F01 → accepted; sum=16'h1000 with done 5 cycles after the previous done. Random 1000-op self-check against a+b+cin.
